// File: rtl/decoder_in_frame_sched.sv
// decoder_in_frame_sched: gates one frame of serial bits (payload + zero tail + even pad) into the RX S2P FIFO
module decoder_in_frame_sched #(
    parameter int LEN_W     = 16,
    parameter int TAIL_BITS = 12,
    parameter int AVAIL_W   = 9,
    parameter int MIN_AVAIL = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frm_start,
    input  logic [LEN_W-1:0]   frm_len,
    input  logic               s_din,
    input  logic               s_vld,
    output logic               s_rdy,
    output logic               m_dout,
    output logic               m_vld,
    input  logic               m_rdy,
    input  logic [AVAIL_W-1:0] fifo_avail,
    output logic               busy,
    output logic [LEN_W:0]     bit_cnt,
    output logic               frm_done,
    output logic               err_len,
    output logic               err_ovr
);
    typedef enum logic [2:0] {IDLE, WAIT_ROOM, PAYLOAD, TAIL, DONE} state_t;
    state_t state, state_nx;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W:0] tail_q, pay_last, tot_last;
    logic accept, xfer;
    // Last-bit indices are formed one bit wider than frm_len so payload + tail never wraps
    assign pay_last = {1'b0, len_q} - (LEN_W+1)'(1);
    assign tot_last = {1'b0, len_q} + tail_q - (LEN_W+1)'(1);
    assign accept   = state == IDLE && frm_start && frm_len != '0;
    assign xfer     = m_vld & m_rdy;
    assign busy     = state != IDLE;
    assign frm_done = state == DONE;
    // Next-state and handshake outputs; PAYLOAD is a zero-latency pass-through
    always_comb begin
        state_nx = state;
        s_rdy    = 1'b0;
        m_vld    = 1'b0;
        m_dout   = 1'b0;
        case (state)
            IDLE:      state_nx = accept ? WAIT_ROOM : IDLE;
            WAIT_ROOM: state_nx = fifo_avail >= AVAIL_W'(MIN_AVAIL) ? PAYLOAD : WAIT_ROOM;
            PAYLOAD: begin
                m_dout   = s_din;
                m_vld    = s_vld;
                s_rdy    = m_rdy;
                state_nx = (s_vld && m_rdy && bit_cnt == pay_last) ? (tail_q != '0 ? TAIL : DONE) : PAYLOAD;
            end
            TAIL: begin
                m_vld    = 1'b1;
                state_nx = (m_rdy && bit_cnt == tot_last) ? DONE : TAIL;
            end
            DONE:      state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end
    // State, frame parameters, bit counter and registered error pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            len_q   <= '0;
            tail_q  <= '0;
            bit_cnt <= '0;
            err_len <= 1'b0;
            err_ovr <= 1'b0;
        end else begin
            state   <= state_nx;
            err_len <= state == IDLE && frm_start && frm_len == '0;
            err_ovr <= state != IDLE && frm_start;
            if (accept) begin
                len_q   <= frm_len;
                tail_q  <= (LEN_W+1)'(TAIL_BITS) + (LEN_W+1)'(frm_len[0]);
                bit_cnt <= '0;
            end else if (xfer) begin
                bit_cnt <= bit_cnt + (LEN_W+1)'(1);
            end
        end
    end
endmodule

// File: tb/tb_decoder_in_frame_sched.sv
// tb_decoder_in_frame_sched: directed frames checked against a bit-stream model of payload + zero tail + pad
module tb_decoder_in_frame_sched;
    localparam int LEN_W = 16;
    localparam int TAIL  = 12;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             frm_start = 1'b0;
    logic [LEN_W-1:0] frm_len = '0;
    logic             s_din = 1'b0;
    logic             s_vld = 1'b0;
    logic             s_rdy;
    logic             m_dout;
    logic             m_vld;
    logic             m_rdy = 1'b0;
    logic [8:0]       fifo_avail = 9'd256;
    logic             busy;
    logic [LEN_W:0]   bit_cnt;
    logic             frm_done;
    logic             err_len;
    logic             err_ovr;

    decoder_in_frame_sched dut (
        .clk(clk), .rst(rst), .frm_start(frm_start), .frm_len(frm_len),
        .s_din(s_din), .s_vld(s_vld), .s_rdy(s_rdy),
        .m_dout(m_dout), .m_vld(m_vld), .m_rdy(m_rdy),
        .fifo_avail(fifo_avail), .busy(busy), .bit_cnt(bit_cnt),
        .frm_done(frm_done), .err_len(err_len), .err_ovr(err_ovr)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // upstream source and frame model: output bit k is src[k] for k<len, else 0; total = len + TAIL + len%2
    bit src [0:511];
    bit out_log [0:511];
    int src_n = 0;
    int ptr = 0;
    bit src_hs = 0;
    int m_len = 0;
    int m_total = 0;
    int idx = 0;
    bit active = 0;
    int done_cnt = 0;
    int vld_pct = 100;
    int rdy_pct = 100;
    bit prev_hold = 0;
    bit prev_dout = 0;

    // compare process: outputs sampled on the falling edge
    always @(negedge clk) begin
        if (rst) begin
            active    = 0;
            idx       = 0;
            prev_hold = 0;
            src_hs    = 0;
        end else begin
            src_hs = s_vld & s_rdy;
            chk("busy", busy, active);
            if (prev_hold) begin
                chk("hold_vld", m_vld, 1);
                chk("hold_dout", m_dout, prev_dout);
            end
            if (!active || idx >= m_len) chk("s_rdy_low", s_rdy, 0);
            if (m_vld && m_rdy) begin
                if (!active || idx >= m_total) chk("extra_xfer", 1, 0);
                else begin
                    chk("bit_cnt", bit_cnt, idx);
                    chk("m_dout", m_dout, idx < m_len ? src[idx] : 0);
                    out_log[idx] = m_dout;
                    idx++;
                end
            end
            if (frm_done) begin
                chk("done_active", active, 1);
                chk("done_count", idx, m_total);
                chk("done_bit_cnt", bit_cnt, m_total);
                active = 0;
                done_cnt++;
            end
            prev_hold = m_vld & ~m_rdy;
            prev_dout = m_dout;
        end
    end

    // upstream AXIS driver and downstream ready generator
    always @(posedge clk) begin
        #1;
        if (src_hs) ptr++;
        m_rdy = $urandom_range(0, 99) < rdy_pct;
        if (!s_vld || src_hs) s_vld = ptr < src_n && $urandom_range(0, 99) < vld_pct;
        s_din = ptr < src_n ? src[ptr] : 1'b0;
    end

    task automatic start(input int len, input bit acc);
        @(posedge clk); #2;
        frm_len   = LEN_W'(len);
        frm_start = 1'b1;
        if (acc) begin
            ptr    = 0;
            src_n  = len;
            s_vld  = 1'b0;
            src_hs = 0;
        end
        @(posedge clk); #2;
        frm_start = 1'b0;
        if (acc) begin
            m_len   = len;
            m_total = len + TAIL + len % 2;
            idx     = 0;
            active  = 1;
        end
    endtask

    task automatic wait_done(input int budget);
        int d0 = done_cnt;
        int k = 0;
        while (done_cnt == d0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        chk("done_timeout", done_cnt != d0, 1);
        @(posedge clk); #2;
    endtask

    task automatic wait_idx(input int n, input int budget);
        int k = 0;
        while (idx < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        chk("reach_idx", idx >= n, 1);
    endtask

    task automatic fill_rand(input int len);
        for (int i = 0; i < len; i++) src[i] = 1'($urandom_range(0, 1));
    endtask

    task automatic fill_pat8();
        logic [7:0] p;
        p = 8'b10110011;
        for (int i = 0; i < 8; i++) src[i] = p[7-i];
    endtask

    initial begin
        logic [19:0] got;
        logic [19:0] exp20;
        exp20 = 20'b10110011_000000000000;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_s_rdy", s_rdy, 0);
        chk("rst_m_vld", m_vld, 0);
        chk("rst_m_dout", m_dout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_bit_cnt", bit_cnt, 0);
        chk("rst_frm_done", frm_done, 0);
        chk("rst_err_len", err_len, 0);
        chk("rst_err_ovr", err_ovr, 0);
        #1 rst = 1'b0;

        fill_pat8();
        start(8, 1);
        wait_done(200);
        for (int i = 0; i < 20; i++) got[19-i] = out_log[i];
        chk("len8_stream", got, exp20);
        chk("len8_bit_cnt", bit_cnt, 20);
        chk("len8_pairs", idx / 2, 10);

        fill_rand(7);
        start(7, 1);
        wait_done(200);
        chk("len7_bit_cnt", bit_cnt, 20);
        chk("len7_even", bit_cnt[0], 0);

        fill_rand(12);
        fifo_avail = 9'd10;
        start(12, 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #2;
            chk("room_s_rdy", s_rdy, 0);
            chk("room_bit_cnt", bit_cnt, 0);
        end
        fifo_avail = 9'd16;
        @(posedge clk); #2;
        chk("room_enter", s_rdy, 1);
        wait_done(200);
        chk("room_bit_cnt_end", bit_cnt, 24);
        fifo_avail = 9'd256;

        vld_pct = 50;
        rdy_pct = 50;
        fill_rand(300);
        start(300, 1);
        wait_done(5000);
        chk("len300_total", idx, 312);
        vld_pct = 100;
        rdy_pct = 100;

        start(0, 0);
        chk("err_len_pulse", err_len, 1);
        chk("err_len_busy", busy, 0);
        @(posedge clk); #2;
        chk("err_len_clear", err_len, 0);

        fill_rand(20);
        start(20, 1);
        wait_idx(5, 200);
        start(4, 0);
        chk("err_ovr_pulse", err_ovr, 1);
        @(posedge clk); #2;
        chk("err_ovr_clear", err_ovr, 0);
        wait_done(200);
        chk("ovr_bit_cnt", bit_cnt, 32);

        fill_rand(100);
        start(100, 1);
        wait_idx(40, 400);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_s_rdy", s_rdy, 0);
        chk("mid_rst_m_vld", m_vld, 0);
        chk("mid_rst_busy", busy, 0);
        @(posedge clk);
        @(posedge clk); #3;
        rst = 1'b0;
        fill_pat8();
        start(8, 1);
        wait_done(200);
        chk("post_rst_bit_cnt", bit_cnt, 20);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
